// File: rtl/interfaz_bus_mem.sv
// Bus controller between the CPU core and byte-wide main memory.
// Word accesses run as two byte cycles, high byte first at A and low byte at A+1 (big-endian).
module interfaz_bus_mem #(
    parameter int ESPERA = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_esc,
    input  logic        i_palabra,
    input  logic [15:0] i_dir_in,
    input  logic [15:0] i_dato_in,
    output logic [15:0] o_dato_out,
    output logic        o_listo,
    output logic        o_ocupado,
    output logic [15:0] o_direccion,
    output logic        o_le,
    inout  logic [7:0]  io_datos
);

    localparam int CW = (ESPERA > 1) ? $clog2(ESPERA) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ESPERA - 1);

    typedef enum logic [2:0] {IDLE, LEER, ESCRIBIR, RECUP, FIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_esc;
    logic          r_palabra;
    logic          r_idx;
    logic [15:0]   r_dir;
    logic [15:0]   r_dato;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_hi;
    logic [15:0]   r_dato_out;
    logic [15:0]   r_direccion;
    logic          r_le;

    logic          w_last;
    logic          w_second;
    logic          w_drv;
    logic [7:0]    w_byte;

    assign w_last   = (r_cnt == '0);
    // A second byte follows only for a word access still on its first byte
    assign w_second = r_palabra && !r_idx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_req) w_next = i_esc ? ESCRIBIR : LEER;
            LEER:     if (w_last) w_next = w_second ? LEER : FIN;
            ESCRIBIR: if (w_last) w_next = RECUP;
            RECUP:    w_next = w_second ? ESCRIBIR : FIN;
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_esc       <= 1'b0;
            r_palabra   <= 1'b0;
            r_idx       <= 1'b0;
            r_dir       <= 16'h0000;
            r_dato      <= 16'h0000;
            r_cnt       <= '0;
            r_hi        <= 8'h00;
            r_dato_out  <= 16'h0000;
            r_direccion <= 16'h0000;
            r_le        <= 1'b1;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_esc       <= i_esc;
                        r_palabra   <= i_palabra;
                        r_dir       <= i_dir_in;
                        r_dato      <= i_dato_in;
                        r_idx       <= 1'b0;
                        r_cnt       <= CNT_LOAD;
                        r_direccion <= i_dir_in;
                        r_le        <= ~i_esc;
                    end
                end
                LEER: begin
                    if (w_last) begin
                        if (w_second) begin
                            r_hi        <= io_datos;
                            r_idx       <= 1'b1;
                            r_cnt       <= CNT_LOAD;
                            r_direccion <= r_dir + 16'd1;
                        end else begin
                            r_dato_out <= r_palabra ? {r_hi, io_datos} : {8'h00, io_datos};
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ESCRIBIR: begin
                    if (w_last) r_le <= 1'b1;
                    else        r_cnt <= r_cnt - CW'(1);
                end
                RECUP: begin
                    if (w_second) begin
                        r_idx       <= 1'b1;
                        r_cnt       <= CNT_LOAD;
                        r_direccion <= r_dir + 16'd1;
                        r_le        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Drive the shared bus only during a write strobe; memory owns it whenever LE is high
    assign w_drv    = ~r_le & r_esc;
    assign w_byte   = w_second ? r_dato[15:8] : r_dato[7:0];
    assign io_datos = w_drv ? w_byte : 8'hzz;

    assign o_dato_out  = r_dato_out;
    assign o_listo     = (r_state == FIN);
    assign o_ocupado   = (r_state != IDLE);
    assign o_direccion = r_direccion;
    assign o_le        = r_le;

endmodule
